// File: rtl/parity_pkg.sv
// Shared constants, stage payload type and slice-parity helper for parity_pipe.
package parity_pkg;

  localparam int unsigned NGRP       = 4;
  localparam int unsigned MAX_DATA_W = 256;

  // Data is carried at maximum width; bits above DATA_W stay zero and fold away.
  typedef struct packed {
    logic [MAX_DATA_W-1:0] data;
    logic                  par_in;
    logic                  odd;
    logic [NGRP-1:0]       part;
  } stage_payload_t;

  function automatic logic [NGRP-1:0] slice_xor(input logic [MAX_DATA_W-1:0] data,
                                                input int unsigned           slice_w);
    logic [NGRP-1:0] part;
    part = '0;
    for (int unsigned g = 0; g < NGRP; g++) begin
      for (int unsigned b = 0; b < MAX_DATA_W / NGRP; b++) begin
        if (b < slice_w) part[2'(g)] = part[2'(g)] ^ data[8'(g * slice_w + b)];
      end
    end
    return part;
  endfunction

endpackage

// File: rtl/parity_pipe_stage.sv
// One elastic register stage: holds a payload plus valid flag, advances when downstream accepts.
module parity_pipe_stage #(
  parameter int unsigned W = 8
) (
  input  logic         Clk_CI,
  input  logic         Rst_RBI,
  input  logic         clk_en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign in_ready  = clk_en & (~valid_q | out_ready);
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) data_q <= in_data;
    end
  end

endmodule

// File: rtl/parity_pipe.sv
// Pipelined parity generator/checker built from elastic valid/ready stages.
// Optional saturating error counter enabled by defining PARITY_PIPE_ERRCNT_EN.
module parity_pipe
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              Clk_CI,
  input  logic              Rst_RBI,
  input  logic              Clk_En,
  input  logic              In_Valid_SI,
  output logic              In_Ready_SO,
  input  logic [DATA_W-1:0] Data_DI,
  input  logic              Par_DI,
  input  logic              Odd_SI,
  output logic              Out_Valid_SO,
  input  logic              Out_Ready_SI,
  output logic [DATA_W-1:0] Data_DO,
  output logic              Par_DO,
  output logic              Err_SO,
  input  logic              ErrClr_SI
`ifdef PARITY_PIPE_ERRCNT_EN
  ,
  output logic [CNT_W-1:0]  ErrCnt_DO
`endif
);

  localparam int unsigned SliceW = DATA_W / NGRP;
  localparam int unsigned PlW    = $bits(stage_payload_t);

  logic [STAGES-1:0]                 st_in_valid, st_in_ready, st_out_valid, st_out_ready;
  stage_payload_t [STAGES-1:0]       st_in;
  stage_payload_t [STAGES-1:0]       st_out;
  stage_payload_t                    head;
  stage_payload_t                    last;
  logic [MAX_DATA_W-1:0]             data_ext;
  logic                              unused_pl;

  assign data_ext = MAX_DATA_W'(Data_DI);

  // The combined parity always lives in part[0] once the partials are folded.
  always_comb begin
    head        = '0;
    head.data   = data_ext;
    head.par_in = Par_DI;
    head.odd    = Odd_SI;
    if (STAGES == 1) head.part[0] = (^Data_DI) ^ Odd_SI;
    else             head.part    = slice_xor(data_ext, SliceW);
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign st_in[i]       = head;
      assign st_in_valid[i] = In_Valid_SI;
    end else if (i == 1) begin : g_combine
      stage_payload_t comb_pl;
      always_comb begin
        comb_pl      = st_out[i-1];
        comb_pl.part = {{(NGRP-1){1'b0}}, (^st_out[i-1].part) ^ st_out[i-1].odd};
      end
      assign st_in[i]       = comb_pl;
      assign st_in_valid[i] = st_out_valid[i-1];
    end else begin : g_delay
      assign st_in[i]       = st_out[i-1];
      assign st_in_valid[i] = st_out_valid[i-1];
    end

    if (i == STAGES - 1) begin : g_tail
      assign st_out_ready[i] = Out_Ready_SI;
    end else begin : g_mid
      assign st_out_ready[i] = st_in_ready[i+1];
    end

    parity_pipe_stage #(
      .W (PlW)
    ) u_stage (
      .Clk_CI    (Clk_CI),
      .Rst_RBI   (Rst_RBI),
      .clk_en    (Clk_En),
      .in_valid  (st_in_valid[i]),
      .in_ready  (st_in_ready[i]),
      .in_data   (st_in[i]),
      .out_valid (st_out_valid[i]),
      .out_ready (st_out_ready[i]),
      .out_data  (st_out[i])
    );
  end

  assign last         = st_out[STAGES-1];
  assign In_Ready_SO  = st_in_ready[0];
  assign Out_Valid_SO = st_out_valid[STAGES-1];
  assign Data_DO      = last.data[DATA_W-1:0];
  assign Par_DO       = last.part[0];
  assign Err_SO       = Out_Valid_SO & (last.part[0] ^ last.par_in);
  assign unused_pl    = ^last;

`ifdef PARITY_PIPE_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             out_err_hs;

  assign out_err_hs = Out_Valid_SO & Out_Ready_SI & Clk_En & Err_SO;

  // A clear coinciding with an erroring handshake still records that error.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (ErrClr_SI) begin
      err_cnt_d = CNT_W'(out_err_hs);
    end else if (out_err_hs && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI)    err_cnt_q <= '0;
    else if (Clk_En) err_cnt_q <= err_cnt_d;
  end

  assign ErrCnt_DO = err_cnt_q;
`else
  logic unused_errclr;
  assign unused_errclr = ErrClr_SI ^ (CNT_W == 0);
`endif

endmodule

// File: doc/parity_pipe.md
PARITY_PIPE -- requirements
Module: parity_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width; multiple of 4, range 4..256.
REQ-002 SHALL have parameter STAGES, default 2, pipeline depth (latency in cycles), range 1..4.
REQ-003 SHALL have parameter CNT_W, default 16, error counter width.
REQ-004 Clk_CI  input  1  clock; all state on rising edge.
REQ-005 Rst_RBI  input  1  reset, asynchronous, active-low.
REQ-006 Clk_En  input  1  clock enable; low freezes all state.
REQ-007 In_Valid_SI  input  1  upstream word valid.
REQ-008 In_Ready_SO  output  1  block accepts word this cycle.
REQ-009 Data_DI  input  DATA_W  data word.
REQ-010 Par_DI  input  1  received parity bit to check.
REQ-011 Odd_SI  input  1  mode: 1 = odd parity, 0 = even parity; sampled per word.
REQ-012 Out_Valid_SO  output  1  result valid.
REQ-013 Out_Ready_SI  input  1  downstream accepts result.
REQ-014 Data_DO  output  DATA_W  delayed data word.
REQ-015 Par_DO  output  1  generated parity bit.
REQ-016 Err_SO  output  1  parity mismatch for word on output.
REQ-017 ErrClr_SI  input  1  synchronous error counter clear.
REQ-018 ErrCnt_DO  output  CNT_W  error count (only with PARITY_PIPE_ERRCNT_EN).

Function
REQ-019 Input handshake SHALL occur when In_Valid_SI & In_Ready_SO & Clk_En; output handshake when Out_Valid_SO & Out_Ready_SI & Clk_En.
REQ-020 Par_DO SHALL equal XOR-reduction of Data_DI, inverted when the word's Odd_SI was 1.
REQ-021 Err_SO SHALL equal Par_DO != word's Par_DI, and SHALL be 0 when Out_Valid_SO is 0.
REQ-022 Stage 1 SHALL register 4 partial parities over DATA_W/4-bit slices; the final stage SHALL combine them; stages beyond 2 are delay-only; STAGES=1 computes full parity in one stage.
REQ-023 Data, Par_DI and Odd_SI SHALL travel with their word through every stage.
REQ-024 Latency SHALL be exactly STAGES enabled cycles from input handshake to Out_Valid_SO with no backpressure.
REQ-025 Throughput SHALL be one word per enabled cycle with Out_Ready_SI held high.
REQ-026 Each stage SHALL hold a valid flag and advance when the next stage is empty or advancing; In_Ready_SO = ~valid[0] | advance[0] (combinational from Out_Ready_SI permitted).
REQ-027 Out_Valid_SO, Data_DO, Par_DO, Err_SO SHALL remain stable while Out_Valid_SO=1 and Out_Ready_SI=0.
REQ-028 With all STAGES full and Out_Ready_SI=0, In_Ready_SO SHALL be 0; no word is dropped or duplicated.
REQ-029 Clk_En=0 SHALL hold all registers and force In_Ready_SO=0; outputs hold their values.

Reset
REQ-030 Rst_RBI low SHALL asynchronously clear all stage valid flags, Out_Valid_SO=0, Data_DO=0, Par_DO=0, Err_SO=0, ErrCnt_DO=0.
REQ-031 Reset mid-operation SHALL discard all in-flight words; In_Ready_SO=1 on first enabled cycle after release.

Configuration
REQ-032 With PARITY_PIPE_ERRCNT_EN defined, ErrCnt_DO SHALL increment on each output handshake with Err_SO=1, saturate at 2^CNT_W-1, clear on ErrClr_SI; clear with simultaneous error SHALL yield 1.
REQ-033 Without PARITY_PIPE_ERRCNT_EN, ErrCnt_DO port and counter SHALL be absent; ErrClr_SI ignored.

Structure
REQ-034 Package parity_pkg SHALL hold NGRP=4 constant, stage payload struct typedef (data, par_in, odd, partial parities) and function for slice XOR reduction.
REQ-035 Sub-module parity_pipe_stage (one elastic register stage with valid/advance) SHALL be instantiated STAGES times via generate.

Verification
REQ-036 DATA_W=32, STAGES=2, Odd_SI=0, Data_DI=0x0000_0007, Par_DI=1 -> after 2 cycles Out_Valid_SO=1, Par_DO=1, Err_SO=0.
REQ-037 Same word, Odd_SI=1, Par_DI=1 -> Par_DO=0, Err_SO=1, ErrCnt_DO 0->1 on handshake.
REQ-038 Stream 10 words, Out_Ready_SI=0 cycles 3..6 -> In_Ready_SO=0 after 2 extra accepts, all 10 words out in order, none lost.
REQ-039 CNT_W=2, 5 erroneous words -> ErrCnt_DO sequence 1,2,3,3,3; ErrClr_SI with error -> 1.
REQ-040 Rst_RBI low with 2 words in flight -> Out_Valid_SO=0 immediately, no stale word after release.
REQ-041 Clk_En=0 for 3 cycles mid-stream -> all outputs frozen, latency extended by 3 cycles exactly.
